frontend_test_sequencer: RTL and testbench

- Controller for the front-end test source mux. It drives the mux's run, data_out_select and triangle_incrmnt inputs.
- Steps through the enabled source modes (0 PCM, 1 +DC, 2 -DC, 3 triangle). Each mode gets a settle period and then a dwell period, both counted in front-end valid strobes.
- Captures the per-mode signed peak of the left channel and flags a stalled front end.
- Sits between the control register block and the front-end mux.

---
 rtl/frontend_test_sequencer_pkg.sv | 56 +++++
 rtl/frontend_test_sequencer_watchdog.sv | 44 ++++
 rtl/frontend_test_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_frontend_test_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_test_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frontend_pkg
// Description : Shared definitions for the front-end test sequencer: source
//               mode encodings, DC reference levels, sequencer state encoding
//               and the enabled-mode search helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frontend_pkg;

    // Front-end source mux mode encodings
    localparam logic [1:0] MODE_PCM    = 2'd0;
    localparam logic [1:0] MODE_POS_DC = 2'd1;
    localparam logic [1:0] MODE_NEG_DC = 2'd2;
    localparam logic [1:0] MODE_TRI    = 2'd3;

    // Levels the front end emits in the DC modes, used by checkers
    localparam logic [23:0] DC_POS_VALUE = 24'h7fff00;
    localparam logic [23:0] DC_NEG_VALUE = 24'h8000ff;

    // Most negative 24-bit value: start point of the peak search
    localparam logic [23:0] PEAK_INIT    = 24'h800000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] mode;
    } mode_pick_t;

    // Lowest enabled mode whose index is >= from. A from value of 4 finds
    // nothing, which is how "no higher mode left" is expressed.
    function automatic mode_pick_t pick_mode(input logic [3:0] mask,
                                             input logic [2:0] from);
        mode_pick_t r;
        r.found = 1'b0;
        r.mode  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((3'(i) >= from) && mask[i]) begin
                r.found = 1'b1;
                r.mode  = 2'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frontend_test_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : fe_strobe_watchdog
// Description : Counts clocks between front-end valid strobes and flags when
//               the gap reaches TIMEOUT_CLKS.
// Ports       : clk, reset_n (async active-low)
//               enable  - count only while the front end should be running
//               clear   - restart the count (entry into the settle phase)
//               strobe  - front-end valid strobe, restarts the count
//               expired - combinational, high on the clock that completes
//                         TIMEOUT_CLKS strobe-free clocks
// Revision    : 1.0 - initial release
// ============================================================================
module fe_strobe_watchdog #(
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic strobe,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CLKS - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (!enable || clear || strobe) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    // A strobe on the expiry clock wins: it restarts the count instead.
    assign expired = enable && !clear && !strobe && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/frontend_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frontend_test_sequencer
// Description : Steps the front-end test source mux through the enabled
//               modes, giving each a settle and a dwell period counted in
//               left-valid strobes, captures the signed left-channel peak of
//               every dwell and flags a stalled front end.
// Ports       : clk, reset_n (async active-low)
//               start/abort, mode_mask, dwell_samples, tri_incrmnt_cfg - control
//               fe_l_valid/fe_l_data      - front-end left channel
//               run/data_out_select/triangle_incrmnt - front-end controls
//               busy/done/error           - sequence status
//               peak_l/peak_mode/peak_valid - per-mode peak result
// Revision    : 1.0 - initial release
// ============================================================================
module frontend_test_sequencer
    import frontend_pkg::*;
#(
    parameter int DWELL_W        = 16,
    parameter int SETTLE_SAMPLES = 8,
    parameter int TIMEOUT_CLKS   = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         mode_mask,
    input  logic [DWELL_W-1:0] dwell_samples,
    input  logic [7:0]         tri_incrmnt_cfg,
    input  logic               fe_l_valid,
    input  logic [23:0]        fe_l_data,
    output logic               run,
    output logic [1:0]         data_out_select,
    output logic [7:0]         triangle_incrmnt,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [23:0]        peak_l,
    output logic [1:0]         peak_mode,
    output logic               peak_valid
);

    localparam logic [7:0] c_settle_last = 8'(SETTLE_SAMPLES - 1);

    seq_state_e          r_state;
    seq_state_e          w_next_state;

    logic [3:0]          r_mask;
    logic [DWELL_W-1:0]  r_dwell_last;     // index of the final dwell strobe
    logic [7:0]          r_tri_cfg;
    logic [7:0]          r_settle_cnt;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [1:0]          r_mode;
    logic [1:0]          r_select;
    logic [7:0]          r_tri_out;
    logic                r_done;
    logic                r_error;
    logic                r_peak_valid;
    logic signed [23:0]  r_peak_acc;
    logic [23:0]         r_peak_l;
    logic [1:0]          r_peak_mode;

    logic                w_idle_like;
    logic                w_start_acc;
    mode_pick_t          w_first;
    mode_pick_t          w_next;
    logic                w_settle_last;
    logic                w_dwell_last;
    logic signed [23:0]  w_data_s;
    logic signed [23:0]  w_new_peak;
    logic                w_wd_expired;

    assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                           (r_state == ST_ERROR);
    assign w_start_acc   = w_idle_like && start && !abort;
    assign w_first       = pick_mode(mode_mask, 3'd0);
    assign w_next        = pick_mode(r_mask, {1'b0, r_mode} + 3'd1);
    assign w_settle_last = fe_l_valid && (r_settle_cnt == c_settle_last);
    assign w_dwell_last  = fe_l_valid && (r_dwell_cnt == r_dwell_last);
    assign w_data_s      = signed'(fe_l_data);
    assign w_new_peak    = (w_data_s > r_peak_acc) ? w_data_s : r_peak_acc;

    fe_strobe_watchdog #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (run),
        .clear   (r_state == ST_ARM),
        .strobe  (fe_l_valid),
        .expired (w_wd_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort outranks everything
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        w_next_state = w_first.found ? ST_ARM : ST_DONE;
                    end
                end
                ST_ARM:    w_next_state = ST_SETTLE;
                ST_SETTLE: begin
                    if (w_settle_last) begin
                        w_next_state = ST_DWELL;
                    end else if (w_wd_expired) begin
                        w_next_state = ST_ERROR;
                    end
                end
                ST_DWELL: begin
                    if (w_dwell_last) begin
                        w_next_state = ST_NEXT;
                    end else if (w_wd_expired) begin
                        w_next_state = ST_ERROR;
                    end
                end
                ST_NEXT:   w_next_state = w_next.found ? ST_ARM : ST_DONE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: configuration latch, counters, peak capture, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask       <= '0;
            r_dwell_last <= '0;
            r_tri_cfg    <= '0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
            r_mode       <= '0;
            r_select     <= '0;
            r_tri_out    <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak_acc   <= '0;
            r_peak_l     <= '0;
            r_peak_mode  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_peak_valid <= 1'b0;
            if (!abort) begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (w_start_acc) begin
                            r_mask       <= mode_mask;
                            // A dwell of 0 behaves as a dwell of 1
                            r_dwell_last <= (dwell_samples == '0) ? '0
                                          : dwell_samples - DWELL_W'(1);
                            r_tri_cfg    <= tri_incrmnt_cfg;
                            r_error      <= 1'b0;
                            r_mode       <= w_first.mode;
                            if (w_first.found) begin
                                r_select  <= w_first.mode;
                                r_tri_out <= tri_incrmnt_cfg;
                            end else begin
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    ST_ARM: begin
                        r_settle_cnt <= '0;
                        r_dwell_cnt  <= '0;
                    end
                    ST_SETTLE: begin
                        if (w_settle_last) begin
                            r_peak_acc  <= signed'(PEAK_INIT);
                            r_dwell_cnt <= '0;
                        end else if (fe_l_valid) begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end else if (w_wd_expired) begin
                            r_error <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (w_dwell_last) begin
                            r_peak_l     <= w_new_peak;
                            r_peak_mode  <= r_mode;
                            r_peak_valid <= 1'b1;
                        end else if (fe_l_valid) begin
                            r_peak_acc  <= w_new_peak;
                            r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                        end else if (w_wd_expired) begin
                            r_error <= 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        if (w_next.found) begin
                            r_mode    <= w_next.mode;
                            r_select  <= w_next.mode;
                            r_tri_out <= r_tri_cfg;
                        end else begin
                            r_done    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign run              = (r_state == ST_SETTLE) || (r_state == ST_DWELL);
    assign busy             = (r_state == ST_ARM) || (r_state == ST_SETTLE) ||
                              (r_state == ST_DWELL) || (r_state == ST_NEXT);
    assign data_out_select  = r_select;
    assign triangle_incrmnt = r_tri_out;
    assign done             = r_done;
    assign error            = r_error;
    assign peak_l           = r_peak_l;
    assign peak_mode        = r_peak_mode;
    assign peak_valid       = r_peak_valid;

endmodule
`default_nettype wire

// File: tb/tb_frontend_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_frontend_test_sequencer
// Description : Self-checking bench for frontend_test_sequencer with a
//               behavioural front end in the loop and a peak scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frontend_test_sequencer;
    import frontend_pkg::*;

    localparam int c_settle  = 8;
    localparam int c_timeout = 4096;
    localparam int c_div     = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  mode_mask = '0;
    logic [15:0] dwell_samples = '0;
    logic [7:0]  tri_incrmnt_cfg = '0;
    logic        fe_l_valid = 1'b0;
    logic [23:0] fe_l_data = '0;
    logic        run;
    logic [1:0]  data_out_select;
    logic [7:0]  triangle_incrmnt;
    logic        busy;
    logic        done;
    logic        error;
    logic [23:0] peak_l;
    logic [1:0]  peak_mode;
    logic        peak_valid;

    always #5 clk = ~clk;

    frontend_test_sequencer #(
        .DWELL_W        (16),
        .SETTLE_SAMPLES (c_settle),
        .TIMEOUT_CLKS   (c_timeout)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .mode_mask        (mode_mask),
        .dwell_samples    (dwell_samples),
        .tri_incrmnt_cfg  (tri_incrmnt_cfg),
        .fe_l_valid       (fe_l_valid),
        .fe_l_data        (fe_l_data),
        .run              (run),
        .data_out_select  (data_out_select),
        .triangle_incrmnt (triangle_incrmnt),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .peak_l           (peak_l),
        .peak_mode        (peak_mode),
        .peak_valid       (peak_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and expectation state
    typedef struct packed {
        logic [23:0] peak;
        logic [1:0]  mode;
    } exp_t;

    exp_t               sb_q[$];
    logic [1:0]         exp_modes[$];
    int                 arm_idx, dwell_idx, dwell_eff;
    int                 n_peaks, n_done, strobe_total, strobe_idx;
    logic [7:0]         cur_incr;
    logic signed [23:0] exp_acc;
    logic [23:0]        tri_val;
    logic [23:0]        last_exp_peak = '0;
    bit                 fe_en = 1'b1;

    // Behavioural front end: strobe every c_div clocks while run is high,
    // data chosen by the DUT's select; also builds the expected peaks.
    initial begin : fe_model
        int   div_cnt;
        exp_t e;
        div_cnt = 0;
        strobe_idx = 0;
        tri_val = '0;
        forever begin
            @(negedge clk);
            fe_l_valid = 1'b0;
            if (!run || !reset_n) begin
                div_cnt    = 0;
                strobe_idx = 0;
                tri_val    = '0;
            end else if (fe_en) begin
                if (div_cnt == c_div - 1) begin
                    div_cnt = 0;
                    strobe_idx++;
                    strobe_total++;
                    case (data_out_select)
                        MODE_PCM:    fe_l_data = 24'($urandom);
                        MODE_POS_DC: fe_l_data = DC_POS_VALUE;
                        MODE_NEG_DC: fe_l_data = DC_NEG_VALUE;
                        default: begin
                            tri_val   = tri_val + {16'd0, triangle_incrmnt};
                            fe_l_data = tri_val;
                        end
                    endcase
                    fe_l_valid = 1'b1;
                    if (strobe_idx == c_settle + 1) exp_acc = 24'sh800000;
                    if (strobe_idx > c_settle) begin
                        if ($signed(fe_l_data) > exp_acc) exp_acc = $signed(fe_l_data);
                        if (strobe_idx == c_settle + dwell_eff) begin
                            e.peak = exp_acc;
                            if (dwell_idx < exp_modes.size()) begin
                                e.mode = exp_modes[dwell_idx];
                            end else begin
                                e.mode = 2'd0;
                                check("extra_dwell", 32'(dwell_idx), 32'(exp_modes.size()));
                            end
                            sb_q.push_back(e);
                            dwell_idx++;
                            last_exp_peak = exp_acc;
                        end
                    end
                end else begin
                    div_cnt++;
                end
            end
        end
    end

    // Output monitor: peak scoreboard, ARM select/increment, select stability
    initial begin : monitor
        logic       prev_run;
        logic [1:0] prev_sel;
        exp_t       e;
        prev_run = 1'b0;
        prev_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (peak_valid) begin
                n_peaks++;
                if (sb_q.size() == 0) begin
                    check("peak_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("peak_l", 32'(peak_l), 32'(e.peak));
                    check("peak_mode", 32'(peak_mode), 32'(e.mode));
                    check("select_at_peak", 32'(data_out_select), 32'(e.mode));
                end
            end
            if (done) n_done++;
            if (run && !prev_run) begin
                if (arm_idx < exp_modes.size())
                    check("arm_select", 32'(data_out_select), 32'(exp_modes[arm_idx]));
                else
                    check("arm_extra", 32'(arm_idx), 32'(exp_modes.size()));
                check("arm_incrmnt", 32'(triangle_incrmnt), 32'(cur_incr));
                arm_idx++;
            end
            if (run && prev_run && (data_out_select != prev_sel))
                check("select_stable", 32'(data_out_select), 32'(prev_sel));
            prev_run = run;
            prev_sel = data_out_select;
        end
    end

    task automatic prep(input logic [3:0] m, input logic [15:0] d, input logic [7:0] inc);
        sb_q.delete();
        exp_modes.delete();
        for (int i = 0; i < 4; i++) if (m[i]) exp_modes.push_back(2'(i));
        arm_idx = 0; dwell_idx = 0; n_peaks = 0; n_done = 0; strobe_total = 0;
        dwell_eff = (d == 16'd0) ? 1 : int'(d);
        cur_incr  = inc;
        mode_mask = m; dwell_samples = d; tri_incrmnt_cfg = inc;
    endtask

    // Pulse start for one clock; returns at the negedge after acceptance
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("error_cleared_on_start", 32'(error), 32'd0);
    endtask

    task automatic run_seq(input logic [3:0] m, input logic [15:0] d, input logic [7:0] inc,
                           input int exp_peaks, input int exp_strobes);
        int cyc;
        prep(m, d, inc);
        kick();
        if (m == 4'd0) begin
            check("done_latency", 32'(done), 32'd1);
            check("run_mask0", 32'(run), 32'd0);
        end
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        check("done_pulses", 32'(n_done), 32'd1);
        check("peak_count", 32'(n_peaks), 32'(exp_peaks));
        check("arm_count", 32'(arm_idx), 32'(exp_peaks));
        check("strobes_used", 32'(strobe_total), 32'(exp_strobes));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("idle_run", 32'(run), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_strobe(input int idx);
        int cyc;
        cyc = 0;
        while (strobe_idx != idx && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_strobe", 32'(strobe_idx), 32'(idx));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run"}, 32'(run), 32'd0);
        check({tag, "_select"}, 32'(data_out_select), 32'd0);
        check({tag, "_incrmnt"}, 32'(triangle_incrmnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_peak_l"}, 32'(peak_l), 32'd0);
        check({tag, "_peak_mode"}, 32'(peak_mode), 32'd0);
        check({tag, "_peak_valid"}, 32'(peak_valid), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] dwell;
        logic [7:0]  incr;
        int          exp_peaks;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[5];

    initial begin : stimulus
        vecs[0] = '{4'b1111, 16'd16, 8'd5,   4, 4 * (c_settle + 16)};
        vecs[1] = '{4'b0100, 16'd0,  8'd3,   1, c_settle + 1};
        vecs[2] = '{4'b0000, 16'd4,  8'd1,   0, 0};
        vecs[3] = '{4'b1010, 16'd3,  8'd7,   2, 2 * (c_settle + 3)};
        vecs[4] = '{4'b1001, 16'd1,  8'd200, 2, 2 * (c_settle + 1)};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_seq(vecs[i].mask, vecs[i].dwell, vecs[i].incr,
                    vecs[i].exp_peaks, vecs[i].exp_strobes);

        // Stalled front end: error after exactly TIMEOUT_CLKS settle clocks
        prep(4'b0001, 16'd4, 8'd0);
        fe_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (c_timeout) @(posedge clk);
        @(negedge clk);
        check("timeout_not_yet_error", 32'(error), 32'd0);
        check("timeout_not_yet_run", 32'(run), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_run", 32'(run), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_error_sticky", 32'(error), 32'd1);
        check("timeout_no_peak", 32'(n_peaks), 32'd0);
        fe_en = 1'b1;
        run_seq(4'b0001, 16'd2, 8'd0, 1, c_settle + 2);

        // Abort (with a simultaneous start) mid-dwell after 5 of 16 strobes
        prep(4'b1000, 16'd16, 8'd9);
        kick();
        wait_strobe(c_settle + 5);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_run", 32'(run), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_peak_valid", 32'(peak_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        check("abort_peak_kept", 32'(peak_l), 32'(last_exp_peak));
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_no_peaks", 32'(n_peaks), 32'd0);

        // Asynchronous reset in the middle of SETTLE
        prep(4'b1111, 16'd16, 8'd5);
        kick();
        wait_strobe(3);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_seq(4'b1111, 16'd16, 8'd5, 4, 4 * (c_settle + 16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
